// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage owning the PC, one-outstanding req/gnt fetch and the IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFFlush,
  input  logic [2:0]  pcsrc_id,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        fetch_busy
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4, target, target_raw;
  logic        redirect, got, retire;
  logic        ifid_valid_q;
  logic [31:0] ifid_instr_q, ifid_pc4_q;
  always_comb begin
    pc4        = pc_q + 32'd4;
    target_raw = (pcsrc_id == 3'b001) ? branch_target :
                 (pcsrc_id == 3'b010) ? jump_target :
                 (pcsrc_id == 3'b011) ? jr_target :
                 (pcsrc_id == 3'b100) ? ILLOP_VEC : XADR_VEC;
    target     = {target_raw[31:2], 2'b00};
    redirect   = PCWrite & (pcsrc_id != 3'b000);
    got        = (state_q != S_REQ) & imem_rvalid;
    retire     = (state_q == S_WAIT) & imem_rvalid & PCWrite & ~IFFlush;
    pc_d       = redirect ? target : retire ? pc4 : pc_q;
    // a grant that coincides with a redirect fetched the old pc, so its data must be discarded
    state_d    = (state_q == S_REQ) ? (imem_gnt ? (redirect ? S_KILL : S_WAIT) : S_REQ) :
                 got ? S_REQ : redirect ? S_KILL : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= retire;
      ifid_instr_q <= retire ? imem_rdata : 32'h0;
      ifid_pc4_q   <= retire ? pc4 : 32'h0;
    end
  end
  assign imem_req   = ~reset & (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign fetch_busy = ~reset & (state_q != S_REQ);
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized and directed checks of the IF stage against a transaction-level model
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, PCWrite, IFFlush;
  logic [2:0]  pcsrc_id;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid, fetch_busy;
  logic [31:0] ifid_instr, ifid_pc4;
  int vecs = 0, errs = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_out, m_dead, m_valid;
  bit          mp, req_pre;
  int          mc;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFFlush(IFFlush), .pcsrc_id(pcsrc_id),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .fetch_busy(fetch_busy)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    chk(n, {31'b0, a}, {31'b0, e});
  endtask

  function automatic logic [31:0] tgt(input logic [2:0] s);
    logic [31:0] t;
    case (s)
      3'd1: t = branch_target;
      3'd2: t = jump_target;
      3'd3: t = jr_target;
      3'd4: t = 32'h8000_0004;
      default: t = 32'h8000_0008;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  // model: pc plus at most one outstanding fetch that may have been killed by a redirect
  task automatic model_update();
    bit redir, got, ret;
    logic [31:0] np;
    if (reset) begin
      m_pc = 32'h8000_0000; m_out = 0; m_dead = 0;
      m_valid = 0; m_instr = 0; m_pc4 = 0;
    end else begin
      redir   = PCWrite && (pcsrc_id != 3'b000);
      got     = m_out && imem_rvalid;
      ret     = got && !m_dead && PCWrite && !IFFlush;
      m_valid = ret;
      m_instr = ret ? imem_rdata : 32'h0;
      m_pc4   = ret ? m_pc + 32'd4 : 32'h0;
      np      = redir ? tgt(pcsrc_id) : ret ? m_pc + 32'd4 : m_pc;
      if (!m_out) begin
        if (imem_gnt) begin m_out = 1; m_dead = redir; end
      end else if (got) begin
        m_out = 0; m_dead = 0;
      end else if (redir) m_dead = 1;
      m_pc = np;
    end
  endtask

  task automatic step();
    #1;
    chk1("imem_req", imem_req, !m_out && !reset);
    chk("imem_addr", imem_addr, m_pc);
    chk1("fetch_busy", fetch_busy, m_out && !reset);
    chk1("ifid_valid", ifid_valid, m_valid);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1; PCWrite = 1; IFFlush = 0; pcsrc_id = 0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    @(posedge clk); model_update(); #1;
    step();
    chk1("lit_rst_valid", ifid_valid, 1'b0);
    chk("lit_rst_pc4", ifid_pc4, 32'h0);
    reset = 0; imem_gnt = 1;
    chk("lit_addr0", imem_addr, 32'h8000_0000);
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2008_0005;
    step();
    imem_rvalid = 0;
    chk("lit_instr", ifid_instr, 32'h2008_0005);
    chk("lit_pc4", ifid_pc4, 32'h8000_0004);
    chk("lit_model_instr", m_instr, 32'h2008_0005);
    for (int k = 1; k < 4; k++) begin
      chk("lit_seq_addr", imem_addr, 32'h8000_0000 + 32'(4 * k));
      imem_gnt = 1; step(); imem_gnt = 0;
      chk1("lit_bubble", ifid_valid, 1'b0);
      imem_rvalid = 1; imem_rdata = $urandom; step(); imem_rvalid = 0;
      chk("lit_seq_pc4", ifid_pc4, 32'h8000_0004 + 32'(4 * k));
    end
    imem_gnt = 1; step(); imem_gnt = 0;
    PCWrite = 0; IFFlush = 1; imem_rvalid = 1; step();
    PCWrite = 1; IFFlush = 0; imem_rvalid = 0;
    chk1("lit_blk_valid", ifid_valid, 1'b0);
    chk("lit_blk_addr", imem_addr, 32'h8000_0010);
    chk1("lit_blk_req", imem_req, 1'b1);
    imem_gnt = 1; step(); imem_gnt = 0;
    pcsrc_id = 3'b011; jr_target = 32'h0040_0010; step(); pcsrc_id = 0;
    chk1("lit_jr_busy", fetch_busy, 1'b1);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 0;
    chk1("lit_jr_drop", ifid_valid, 1'b0);
    chk("lit_jr_addr", imem_addr, 32'h0040_0010);
    pcsrc_id = 3'b100; imem_gnt = 1; step(); pcsrc_id = 0; imem_gnt = 0;
    chk1("lit_illop_busy", fetch_busy, 1'b1);
    chk("lit_illop_addr", imem_addr, 32'h8000_0004);
    imem_rvalid = 1; step(); imem_rvalid = 0;
    chk1("lit_illop_drop", ifid_valid, 1'b0);
    chk1("lit_illop_req", imem_req, 1'b1);
    pcsrc_id = 3'b111; step(); pcsrc_id = 0;
    chk("lit_xadr_addr", imem_addr, 32'h8000_0008);
    pcsrc_id = 3'b010; jump_target = 32'hFFFF_FFFF; step(); pcsrc_id = 0;
    chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h1234_5678; step(); imem_rvalid = 0;
    chk("lit_wrap_pc4", ifid_pc4, 32'h0);
    chk("lit_wrap_next", imem_addr, 32'h0);
    imem_gnt = 1; step(); imem_gnt = 0;
    reset = 1; step(); reset = 0;
    chk1("lit_rw_valid", ifid_valid, 1'b0);
    chk1("lit_rw_busy", fetch_busy, 1'b0);
    chk("lit_rw_addr", imem_addr, 32'h8000_0000);
    imem_rvalid = 1; step(); imem_rvalid = 0;
    chk1("lit_stale_rvalid", ifid_valid, 1'b0);
    chk1("lit_stale_req", imem_req, 1'b1);
    mp = 0; mc = 0;
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom % 256) == 0;
      PCWrite       = ($urandom % 6) != 0;
      IFFlush       = ($urandom % 8) == 0;
      pcsrc_id      = (($urandom % 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      imem_gnt      = 1'($urandom_range(0, 1));
      imem_rvalid   = mp ? (mc == 0) : (($urandom % 8) == 0);
      imem_rdata    = $urandom;
      req_pre       = !m_out && !reset;
      step();
      if (reset) mp = 0;
      else begin
        if (mp && imem_rvalid) mp = 0;
        else if (mp) mc--;
        if (req_pre && imem_gnt) begin mp = 1; mc = int'($urandom % 3); end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
